// File: rtl/rgb_pwm_ctrl_pkg.sv
// Shared definitions for the RGB PWM controller: register map, CTRL bit positions,
// PWM width and the breathe duty-scaling helper.
package rgb_pwm_ctrl_pkg;

   localparam int PWM_W    = 8;
   localparam int NUM_CHAN = 3;

   localparam logic [PWM_W-1:0] PWM_MAX = 8'hFF;

   typedef enum logic [1:0] {
      ADDR_CTRL  = 2'd0,
      ADDR_DUTY0 = 2'd1,
      ADDR_DUTY1 = 2'd2,
      ADDR_DUTY2 = 2'd3
   } reg_addr_e;

   localparam int CTRL_EN_BIT      = 0;
   localparam int CTRL_BREATHE_BIT = 1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } breathe_dir_e;

   // Upper byte of duty*level, so level 255 gives just under full duty.
   function automatic logic [PWM_W-1:0] scale_duty(input logic [PWM_W-1:0] duty,
                                                   input logic [PWM_W-1:0] level);
      logic [2*PWM_W-1:0] prod;
      prod = {{PWM_W{1'b0}}, duty} * {{PWM_W{1'b0}}, level};
      return prod[2*PWM_W-1:PWM_W];
   endfunction

endpackage

// File: rtl/rgb_pwm_ctrl_chan.sv
// One PWM channel: duty shadow register reloaded at the period boundary, compare
// against the shared period counter, and a registered output.
module rgb_pwm_ctrl_chan
   import rgb_pwm_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [PWM_W-1:0] duty,
   input  logic [PWM_W-1:0] eff_duty,
   input  logic [PWM_W-1:0] pwm_cnt,
   output logic             pwm_o
);

   logic [PWM_W-1:0] shadow_q;
   logic [PWM_W-1:0] shadow_d;
   logic             pwm_q;
   logic             pwm_d;

   // While disabled the shadow follows the programmed duty so a fresh enable
   // starts its first frame with the current value rather than a stale one.
   always_comb begin
      shadow_d = shadow_q;
      if (!en) begin
         shadow_d = duty;
      end else if (load) begin
         shadow_d = eff_duty;
      end
      pwm_d = en & (pwm_cnt < shadow_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o = en & pwm_q;

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// CPU-programmable 3-channel PWM for the RGB LED driver. Define RGB_PWM_BREATHE_EN
// to add the CTRL.BREATHE triangle-level modulation of all channel duties.
module rgb_pwm_ctrl
   import rgb_pwm_ctrl_pkg::*;
#(
   parameter int PRESCALE = 47
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic [2:0] pwm_o,
   output logic       frame_o
);

   localparam int PRESC_W = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE);

   reg_addr_e addr_e;
   logic      wr;
   logic      rd;
   logic      tick;
   logic      boundary;
   logic      breathe_bit;

   logic                              en_q;
   logic                              en_d;
   logic [NUM_CHAN-1:0][PWM_W-1:0]    duty_q;
   logic [NUM_CHAN-1:0][PWM_W-1:0]    duty_d;
   logic [NUM_CHAN-1:0][PWM_W-1:0]    eff_duty;
   logic [PRESC_W-1:0]                presc_q;
   logic [PRESC_W-1:0]                presc_d;
   logic [PWM_W-1:0]                  cnt_q;
   logic [PWM_W-1:0]                  cnt_d;

   assign addr_e = reg_addr_e'(addr);
   assign wr     = cs & we;
   assign rd     = cs & ~we;

   always_comb begin
      en_d   = en_q;
      duty_d = duty_q;
      if (wr) begin
         case (addr_e)
            ADDR_CTRL:  en_d      = din[CTRL_EN_BIT];
            ADDR_DUTY0: duty_d[0] = din;
            ADDR_DUTY1: duty_d[1] = din;
            ADDR_DUTY2: duty_d[2] = din;
            default:    en_d      = en_q;
         endcase
      end
   end

   // The period boundary is the tick that wraps pwm_cnt from 255 back to 0.
   assign tick     = en_q & (presc_q == PRESC_LAST);
   assign boundary = tick & (cnt_q == PWM_MAX);
   assign frame_o  = boundary;

   always_comb begin
      presc_d = '0;
      cnt_d   = '0;
      if (en_q) begin
         presc_d = tick ? '0 : presc_q + PRESC_W'(1);
         cnt_d   = tick ? cnt_q + PWM_W'(1) : cnt_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q    <= 1'b0;
         duty_q  <= '0;
         presc_q <= '0;
         cnt_q   <= '0;
      end else begin
         en_q    <= en_d;
         duty_q  <= duty_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef RGB_PWM_BREATHE_EN
   logic         breathe_q;
   logic         breathe_d;
   logic [PWM_W-1:0] level_q;
   logic [PWM_W-1:0] level_d;
   breathe_dir_e dir_q;
   breathe_dir_e dir_d;
   logic [7:0]   unused_din;

   assign unused_din = din & 8'hFC;

   // Level walks 0->255->0 one step per frame, turning around at each end.
   always_comb begin
      breathe_d = breathe_q;
      level_d   = level_q;
      dir_d     = dir_q;
      if (wr && (addr_e == ADDR_CTRL)) begin
         breathe_d = din[CTRL_BREATHE_BIT];
      end
      if (!breathe_q) begin
         level_d = '0;
         dir_d   = DIR_UP;
      end else if (boundary) begin
         if (dir_q == DIR_UP) begin
            if (level_q == PWM_MAX) begin
               dir_d   = DIR_DOWN;
               level_d = level_q - PWM_W'(1);
            end else begin
               level_d = level_q + PWM_W'(1);
            end
         end else begin
            if (level_q == '0) begin
               dir_d   = DIR_UP;
               level_d = level_q + PWM_W'(1);
            end else begin
               level_d = level_q - PWM_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         breathe_q <= 1'b0;
         level_q   <= '0;
         dir_q     <= DIR_UP;
      end else begin
         breathe_q <= breathe_d;
         level_q   <= level_d;
         dir_q     <= dir_d;
      end
   end

   always_comb begin
      eff_duty = duty_q;
      if (breathe_q) begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            eff_duty[i] = scale_duty(duty_q[i], level_q);
         end
      end
   end

   assign breathe_bit = breathe_q;
`else
   logic [7:0] unused_din;

   assign unused_din  = din & 8'hFE;
   assign eff_duty    = duty_q;
   assign breathe_bit = 1'b0;
`endif

   always_comb begin
      dout = '0;
      if (rd) begin
         case (addr_e)
            ADDR_CTRL:  dout = {6'b0, breathe_bit, en_q};
            ADDR_DUTY0: dout = duty_q[0];
            ADDR_DUTY1: dout = duty_q[1];
            ADDR_DUTY2: dout = duty_q[2];
            default:    dout = '0;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
      rgb_pwm_ctrl_chan u_chan (
         .clk      (clk),
         .reset    (reset),
         .en       (en_q),
         .load     (boundary),
         .duty     (duty_q[i]),
         .eff_duty (eff_duty[i]),
         .pwm_cnt  (cnt_q),
         .pwm_o    (pwm_o[i])
      );
   end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Self-checking bench for rgb_pwm_ctrl: per-frame high-time scoreboard plus
// register, enable and reset checks.
module tb_rgb_pwm_ctrl;

   localparam int TbPrescale  = 3;
   localparam int TickClk     = TbPrescale + 1;
   localparam int FrameClk    = 256 * TickClk;
   localparam int FrameBudget = FrameClk + 100;

`ifdef RGB_PWM_BREATHE_EN
   localparam logic [7:0] ExpBreatheOnly = 8'h02;
`else
   localparam logic [7:0] ExpBreatheOnly = 8'h00;
`endif

   logic       clk;
   logic       reset;
   logic       cs;
   logic       we;
   logic [1:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic [2:0] pwm_o;
   logic       frame_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int hi0;
      int hi1;
      int hi2;
   } frameExp_t;

   frameExp_t expQ[$];

   int hiCount [3];
   int cyclesSinceFrame = 0;
   int armSeq = 0;
   int seenArm = 0;

   rgb_pwm_ctrl #(.PRESCALE(TbPrescale)) dut (
      .clk     (clk),
      .reset   (reset),
      .cs      (cs),
      .we      (we),
      .addr    (addr),
      .din     (din),
      .dout    (dout),
      .pwm_o   (pwm_o),
      .frame_o (frame_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // One bus write, landing on the next rising edge.
   task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
      cs   = 1'b1;
      we   = 1'b1;
      addr = a;
      din  = d;
      @(posedge clk);
      #1;
      cs   = 1'b0;
      we   = 1'b0;
   endtask

   task automatic checkRead(input string tag, input logic [1:0] a, input logic [7:0] expected);
      cs   = 1'b1;
      we   = 1'b0;
      addr = a;
      #1;
      checkOutput(tag, int'(dout), int'(expected));
      cs   = 1'b0;
   endtask

   // Expected high time per frame is duty ticks of PRESCALE+1 clocks each.
   task automatic pushExpected(input int d0, input int d1, input int d2);
      frameExp_t e;
      e.hi0 = d0 * TickClk;
      e.hi1 = d1 * TickClk;
      e.hi2 = d2 * TickClk;
      expQ.push_back(e);
   endtask

   // Returns shortly after the rising edge that opens a frame_o cycle.
   task automatic waitFrame(input string tag);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < FrameBudget; n++) begin
         @(posedge clk);
         #2;
         if (frame_o) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) checkOutput({tag, "_timeout"}, 0, 1);
   endtask

   // Monitor: accumulate high cycles between frame strobes and score each frame.
   always @(negedge clk) begin
      frameExp_t e;
      if (armSeq != seenArm) begin
         seenArm = armSeq;
         for (int i = 0; i < 3; i++) hiCount[i] = 0;
         cyclesSinceFrame = 0;
      end
      for (int i = 0; i < 3; i++) if (pwm_o[i]) hiCount[i]++;
      cyclesSinceFrame++;
      if (frame_o) begin
         if (expQ.size() == 0) begin
            checkOutput("sb_underflow", 1, 0);
         end else begin
            e = expQ.pop_front();
            checkOutput("frame_hi0", hiCount[0], e.hi0);
            checkOutput("frame_hi1", hiCount[1], e.hi1);
            checkOutput("frame_hi2", hiCount[2], e.hi2);
            checkOutput("frame_period", cyclesSinceFrame, FrameClk);
         end
         for (int i = 0; i < 3; i++) hiCount[i] = 0;
         cyclesSinceFrame = 0;
      end
   end

   initial begin
      int stray;
      reset = 1'b0;
      cs    = 1'b0;
      we    = 1'b0;
      addr  = 2'd0;
      din   = 8'd0;

      // Reset state and register reads while reset is held.
      repeat (3) @(negedge clk);
      checkOutput("rst_pwm", int'(pwm_o), 0);
      checkOutput("rst_frame", int'(frame_o), 0);
      for (int a = 0; a < 4; a++) checkRead("rst_read", 2'(a), 8'h00);
      reset = 1'b1;
      @(posedge clk);
      #1;
      for (int a = 0; a < 4; a++) checkRead("post_rst_read", 2'(a), 8'h00);

      // Duties 64 / 0 / 255, then enable; first two frames use them.
      applyStimulus(2'd1, 8'd64);
      applyStimulus(2'd2, 8'd0);
      applyStimulus(2'd3, 8'd255);
      checkRead("rd_duty0", 2'd1, 8'd64);
      checkRead("rd_duty2", 2'd3, 8'd255);
      pushExpected(64, 0, 255);
      pushExpected(64, 0, 255);
      applyStimulus(2'd0, 8'h01);
      armSeq++;
      checkRead("rd_ctrl_en", 2'd0, 8'h01);

      waitFrame("frame1");
      repeat (100) @(negedge clk);
      applyStimulus(2'd1, 8'd100);
      pushExpected(100, 0, 255);

      // Write lands on the boundary edge: shadow keeps 100, 200 follows a frame later.
      waitFrame("frame2");
      applyStimulus(2'd1, 8'd200);
      pushExpected(200, 0, 255);
      waitFrame("frame3");
      waitFrame("frame4");

      // Disable mid-frame, reprogram, re-enable.
      repeat (300) @(negedge clk);
      checkOutput("mid_frame_pwm", int'(pwm_o), 3'b101);
      applyStimulus(2'd0, 8'h00);
      @(negedge clk);
      checkOutput("dis_pwm", int'(pwm_o), 0);
      checkOutput("dis_frame", int'(frame_o), 0);
      applyStimulus(2'd1, 8'd32);
      applyStimulus(2'd2, 8'd128);
      applyStimulus(2'd3, 8'd8);
      applyStimulus(2'd0, 8'hFC);
      checkRead("rd_ctrl_hi_ignored", 2'd0, 8'h00);
      applyStimulus(2'd0, 8'h02);
      checkRead("rd_ctrl_breathe", 2'd0, ExpBreatheOnly);
      applyStimulus(2'd0, 8'h03);
      checkRead("rd_ctrl_both", 2'd0, 8'h01 | ExpBreatheOnly);
      applyStimulus(2'd0, 8'h00);
      checkRead("rd_duty1", 2'd2, 8'd128);
      pushExpected(32, 128, 8);
      applyStimulus(2'd0, 8'h01);
      armSeq++;
      waitFrame("frame_reen");

      // Asynchronous reset in the middle of a frame.
      repeat (200) @(negedge clk);
      checkOutput("pre_reset_pwm", int'(pwm_o), 3'b010);
      #3;
      reset = 1'b0;
      #1;
      checkOutput("async_rst_pwm", int'(pwm_o), 0);
      checkOutput("async_rst_frame", int'(frame_o), 0);
      for (int a = 0; a < 4; a++) checkRead("async_rst_read", 2'(a), 8'h00);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      for (int a = 0; a < 4; a++) checkRead("rel_read", 2'(a), 8'h00);
      stray = 0;
      repeat (50) begin
         @(negedge clk);
         if (pwm_o != 3'b000 || frame_o) stray++;
      end
      checkOutput("post_rst_quiet", stray, 0);
      checkOutput("sb_leftover", expQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
